// File: rtl/mem_stage_sram_ctrl.sv
// Memory pipeline stage: moves 32-bit load/store words over a 16-bit SRAM as two half-word
// phases (low half first) and freezes the pipeline via ready while an access is in flight.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        val_rm,
    input  logic [3:0]         dest,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [31:0]        alu_res_out,
    output logic [3:0]         dest_out,
    output logic [31:0]        mem_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPhLo, StPhHi, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                store_q, store_d;
    logic [31:0]         data_q, data_d;
    logic [SRAM_AW-2:0]  word_q, word_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         mem_data_q, mem_data_d;

    logic                req;
    logic                in_hi;
    logic                phase_last;
    logic [31:0]         off;
    logic                unused_off;

    assign wb_en_out    = wb_en;
    assign mem_r_en_out = mem_r_en;
    assign alu_res_out  = alu_res;
    assign dest_out     = dest;
    assign mem_data     = mem_data_q;

    assign req        = mem_r_en | mem_w_en;
    assign in_hi      = (state_q == StPhHi);
    assign phase_last = (cnt_q == CntLast);

    // Only the word index is kept; the byte offset within a word is ignored.
    assign off        = alu_res - 32'(BASE_ADDR);
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        data_d      = data_q;
        word_d      = word_q;
        lo_d        = lo_q;
        mem_data_d  = mem_data_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;

        unique case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) begin
                    store_d = mem_w_en;
                    data_d  = val_rm;
                    word_d  = off[SRAM_AW:2];
                    cnt_d   = '0;
                    state_d = StPhLo;
                end
            end
            StPhLo, StPhHi: begin
                sram_addr  = {word_q, in_hi};
                sram_we_n  = ~store_q;
                sram_dq_oe = store_q;
                if (store_q) begin
                    sram_dq_out = in_hi ? data_q[31:16] : data_q[15:0];
                end
                cnt_d = cnt_q + CntW'(1);
                if (phase_last) begin
                    cnt_d = '0;
                    if (!in_hi) begin
                        state_d = StPhHi;
                        if (!store_q) lo_d = sram_dq_in;
                    end else begin
                        state_d = StDone;
                        if (!store_q) mem_data_d = {sram_dq_in, lo_q};
                    end
                end
            end
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            word_q     <= '0;
            lo_q       <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_q    <= store_d;
            data_q     <= data_d;
            word_q     <= word_d;
            lo_q       <= lo_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory stage: consumes the EXE/MEM pipeline register outputs and performs data-memory loads/stores on an external 16-bit SRAM.
- Each 32-bit word is moved as two half-word accesses, low half first.
- Drives `ready` low while an access is in flight, so the hazard/freeze logic stalls all earlier stages.
- Passes write-back controls and the read data on to the MEM/WB register.

Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM half-word 0.
- `ACCESS_CYCLES`, 2: cycles per half-word phase (≥1).
- `SRAM_AW`, 18: SRAM half-word address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wb_en`  in  1  write-back enable from EXE/MEM.
- `mem_r_en`  in  1  load request.
- `mem_w_en`  in  1  store request.
- `alu_res`  in  32  byte address (or ALU result for non-memory ops).
- `val_rm`  in  32  store data.
- `dest`  in  4  destination register.
- `wb_en_out`  out  1  = `wb_en` (combinational pass-through).
- `mem_r_en_out`  out  1  = `mem_r_en`.
- `alu_res_out`  out  32  = `alu_res`.
- `dest_out`  out  4  = `dest`.
- `mem_data`  out  32  last completed load word.
- `ready`  out  1  1 = stage may advance; 0 = freeze pipeline.
- `sram_addr`  out  SRAM_AW  half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_dq_out`  out  16  write data to pad.
- `sram_dq_oe`  out  1  pad output enable (1 = drive).
- `sram_dq_in`  in  16  read data from pad.

Behaviour:
- States: IDLE, PH_LO, PH_HI, DONE. Phase counter `cnt` counts 0..ACCESS_CYCLES-1.
- Request `req` = `mem_r_en | mem_w_en`. If both are set, treat as a store.
- IDLE with `req` = 1:
  - Latch op type, `val_rm`, and `off = alu_res - BASE_ADDR` (32-bit, wraps).
  - Next state PH_LO, `cnt` = 0.
  - Later input changes are ignored until DONE.
- Address mapping: `sram_addr = {off[SRAM_AW:2], half}`, where half = 0 in PH_LO and 1 in PH_HI. `off[1:0]` is ignored (word-aligned only).
- PH_LO / PH_HI:
  - `cnt` increments each cycle.
  - On `cnt` = ACCESS_CYCLES-1, advance PH_LO→PH_HI (`cnt` = 0) or PH_HI→DONE.
- Store:
  - `sram_we_n` = 0 and `sram_dq_oe` = 1 for every cycle of both phases.
  - `sram_dq_out` = latched data [15:0] in PH_LO, [31:16] in PH_HI.
- Load:
  - `sram_we_n` = 1, `sram_dq_oe` = 0.
  - `sram_dq_in` is sampled on the last cycle of each phase into the lo/hi holding regs.
- DONE:
  - `mem_data` updates to {hi, lo}, loads only, registered at the PH_HI→DONE edge.
  - Stores leave `mem_data` unchanged.
  - Next state IDLE.
- `ready` (combinational) = 1 in DONE, or in IDLE with `req` = 0; otherwise 0.
- Latency: 2·ACCESS_CYCLES+2 cycles from the first `req` cycle to the DONE cycle. `ready` is low for 2·ACCESS_CYCLES+1 cycles. Default: 6 cycles, `ready` low for 5.
- Back-to-back requests: the pipeline advances on the DONE cycle. A new `req` seen in the following IDLE cycle starts a fresh access; no overlap.
- Idle SRAM outputs: `sram_addr` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_dq_out` = 0.
- Reset (`rst` = 0 at edge):
  - State IDLE, `cnt` 0, latches and `mem_data` = 0.
  - Mid-access reset aborts immediately. A partial store leaves the low half written; no recovery.
  - `ready` after reset follows the IDLE rule.
- Pass-through outputs carry no register and no reset value; they equal their inputs.

Test Plan:
- Reset: `rst`=0 for 2 cycles with `mem_w_en`=1 → `sram_we_n`=1, `sram_dq_oe`=0, `mem_data`=0; after release, `ready`=0 the same cycle.
- Store then load:
  - Store with `alu_res`=1028, `val_rm`=0xDEADBEEF → `sram_addr`=2 writing 0xBEEF for 2 cycles, then `sram_addr`=3 writing 0xDEAD for 2 cycles.
  - `ready`=0 for 5 cycles, 1 on cycle 6.
  - Load from 1028 with SRAM model → `mem_data`=0xDEADBEEF at DONE.
- Non-memory op (`req`=0, `alu_res`=0x55) → `ready`=1 every cycle, no SRAM activity, `alu_res_out`=0x55.
- Back-to-back loads at 1024 then 1032 → two 6-cycle accesses, addresses 0,1 then 4,5; `mem_data` updates twice.
- Input change mid-access: alter `alu_res` to 2000 during PH_LO → access completes at the original address.
- Reset during PH_HI of a store → IDLE next cycle, `sram_we_n`=1; only the low half is written.
- ACCESS_CYCLES=1 build → 4-cycle access, `ready` low 3 cycles.
